bit_count_feeder: RTL and testbench

Upstream feeder for the 32-bit bit-counter stage. It buffers producer words in a small FIFO and issues them one at a time to the counter using the counter's Valid/Ready protocol. It waits for each count to complete, then returns the count on a result port tagged with a sequence number. It sits between the word source and the counter and decouples bursty producers from the counter's two-cycle turnaround.

---
 rtl/bit_count_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_bit_count_feeder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_count_feeder.sv
// bit_count_feeder: buffers 32-bit producer words in a small FIFO and hands them one
// at a time to the bit-counter stage over its Valid/Ready handshake. Each count is
// returned on the result port with a wrapping sequence tag.
// Optional build macro BCF_TIMEOUT_EN adds a watchdog on the two wait states: a stuck
// counter produces a 6'h3F result, sets the sticky err flag and returns the FSM to idle.
module bit_count_feeder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    output logic                     cnt_valid,
    output logic [31:0]              cnt_data,
    input  logic                     cnt_ready,
    input  logic [31:0]              cnt_result,
    output logic                     res_valid,
    output logic [5:0]               res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitLow,
        StWaitHigh
    } state_t;

    // FIFO storage and bookkeeping
    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;

    // FSM and registered outputs
    state_t           r_state;
    logic             r_cnt_valid;
    logic [31:0]      r_cnt_data;
    logic             r_res_valid;
    logic [5:0]       r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic [TAG_W-1:0] r_issue_tag;
    logic [TAG_W-1:0] r_tag;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_in_wait;
    logic             w_wait_exit;
    logic             w_timeout;
    logic             w_unused;

    // Full/empty come from the registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_full   = (r_fill == FW'(DEPTH));
    assign w_empty  = (r_fill == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == StIdle) && !w_empty && cnt_ready;

    assign w_in_wait   = (r_state == StWaitLow) || (r_state == StWaitHigh);
    assign w_wait_exit = ((r_state == StWaitLow) && !cnt_ready) ||
                         ((r_state == StWaitHigh) && cnt_ready);

    // Only the low six result bits carry the count.
    assign w_unused = ^{cnt_result[31:6], (TIMEOUT == 0)};

    // FIFO data write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FW'(1);
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - FW'(1);
            end
        end
    end

    // Issue/wait FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt_valid <= 1'b0;
            r_cnt_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_issue_tag <= '0;
            r_tag       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_cnt_data  <= r_mem[r_rd_ptr];
                        r_cnt_valid <= 1'b1;
                        r_issue_tag <= r_tag;
                        r_tag       <= r_tag + TAG_W'(1);
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    r_cnt_valid <= 1'b0;
                    r_state     <= StWaitLow;
                end
                StWaitLow: begin
                    // Counter acknowledges the start pulse by dropping Ready.
                    if (!cnt_ready) begin
                        r_state <= StWaitHigh;
                    end else if (w_timeout) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= 6'h3F;
                        r_res_tag   <= r_issue_tag;
                        r_state     <= StIdle;
                    end
                end
                StWaitHigh: begin
                    // Ready returning high marks the count as complete.
                    if (cnt_ready) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= cnt_result[5:0];
                        r_res_tag   <= r_issue_tag;
                        r_state     <= StIdle;
                    end else if (w_timeout) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= 6'h3F;
                        r_res_tag   <= r_issue_tag;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef BCF_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wd_cnt;
    logic          r_err;

    // Fires on the last allowed cycle in a wait state unless the state is being left anyway.
    assign w_timeout = w_in_wait && !w_wait_exit && (r_wd_cnt == TW'(TIMEOUT - 1));

    // Watchdog: counts cycles in the current wait state; err is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (!w_in_wait || w_wait_exit) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + TW'(1);
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign in_ready  = !w_full;
    assign cnt_valid = r_cnt_valid;
    assign cnt_data  = r_cnt_data;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_tag   = r_res_tag;
    assign fill      = r_fill;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_bit_count_feeder.sv
// Testbench for bit_count_feeder: directed table vectors, hand-written corner
// sequences and a randomized phase, all scored against a queue-based reference model.
module tb_bit_count_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned FW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [31:0]       in_data = 32'h0;
    logic              in_ready;
    logic              cnt_valid;
    logic [31:0]       cnt_data;
    logic              cnt_ready;
    logic [31:0]       cnt_result;
    logic              res_valid;
    logic [5:0]        res_data;
    logic [TAG_W-1:0]  res_tag;
    logic [FW-1:0]     fill;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    bit_count_feeder #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cnt_valid  (cnt_valid),
        .cnt_data   (cnt_data),
        .cnt_ready  (cnt_ready),
        .cnt_result (cnt_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .fill       (fill),
        .busy       (busy),
        .err        (err)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic report_fail(input string name, input string act, input string req);
        checks++;
        failures++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    // Counter stand-in: drops Ready the edge after seeing Valid, raises it again one
    // cycle later (or later while hold_low is set). no_resp models a dead counter.
    int unsigned mode     = 0;
    logic        stall    = 1'b0;
    logic        hold_low = 1'b0;
    logic        no_resp  = 1'b0;
    logic        m_ready  = 1'b1;
    logic [31:0] m_result = 32'h0;

    function automatic logic [5:0] exp_count(input logic [31:0] w);
        if (mode == 1) return w[5:0];
        return 6'($countones(w));
    endfunction

    assign cnt_ready  = m_ready && !stall;
    assign cnt_result = m_result;

    always @(posedge clk) begin
        if (cnt_valid && !no_resp) begin
            m_ready  <= 1'b0;
            m_result <= {26'h2AAAAAA, exp_count(cnt_data)};
        end else if (!m_ready && !hold_low) begin
            m_ready <= 1'b1;
        end
    end

    // Reference model: FIFO of accepted words, queue of expected {tag, count} results.
    logic [31:0]      q_words [$];
    logic [TAG_W+5:0] q_res [$];
    int unsigned      tag_m = 0;
    int unsigned      n_res = 0;
    bit               expect_timeout = 1'b0;
    logic [31:0]      mon_w;
    logic [TAG_W+5:0] mon_e;

    always @(negedge clk) begin
        if (cnt_valid) begin
            if (q_words.size() == 0) begin
                report_fail("issue_unexpected", "issue", "none");
            end else begin
                mon_w = q_words.pop_front();
                check("cnt_data", cnt_data, mon_w);
                q_res.push_back({TAG_W'(tag_m % (1 << TAG_W)),
                                 (expect_timeout ? 6'h3F : exp_count(mon_w))});
                tag_m++;
            end
        end
        if (res_valid) begin
            if (q_res.size() == 0) begin
                report_fail("res_unexpected", "result", "none");
            end else begin
                mon_e = q_res.pop_front();
                check("res_data", 32'(res_data), 32'(mon_e[5:0]));
                check("res_tag", 32'(res_tag), 32'(mon_e[TAG_W+5:6]));
                n_res++;
            end
        end
        if (rst) begin
            q_words.delete();
            q_res.delete();
            tag_m = 0;
        end else begin
            check("fill", 32'(fill), 32'(q_words.size()));
            check("in_ready", 32'(in_ready), 32'(q_words.size() < DEPTH));
            if (in_valid && in_ready) q_words.push_back(in_data);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) report_fail("send_accept", "never_ready", "accepted");
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (q_words.size() == 0 && q_res.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) report_fail(name, "pending_work", "drained");
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] word;
        logic [5:0]  cnt;
    } vec_t;

    vec_t             tbl [7];
    logic [31:0]      t2 [5];
    int               lat;
    logic             cv1, cv2, rv_after;
    logic [5:0]       rd;
    logic [TAG_W-1:0] rt;
    int               spur;
    bit               acc;
    int unsigned      n_before;

    initial begin
        tbl[0] = '{32'h0000_00FF, 6'd8};
        tbl[1] = '{32'h0000_0000, 6'd0};
        tbl[2] = '{32'hFFFF_FFFF, 6'd32};
        tbl[3] = '{32'h8000_0001, 6'd2};
        tbl[4] = '{32'h0F0F_0F0F, 6'd16};
        tbl[5] = '{32'h1234_5678, 6'd13};
        tbl[6] = '{32'h7FFF_FFFF, 6'd31};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_cnt_valid", 32'(cnt_valid), 0);
        check("rst_cnt_data", cnt_data, 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_tag", 32'(res_tag), 0);
        check("rst_fill", 32'(fill), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table: single words into an idle feeder, timing and value of each result
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].word;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = -1; cv1 = 1'b0; cv2 = 1'b1; rv_after = 1'b1; rd = '0; rt = '0;
            for (int k = 0; k <= 12; k++) begin
                @(negedge clk);
                if (k == 1) cv1 = cnt_valid;
                if (k == 2) cv2 = cnt_valid;
                if (lat >= 0 && k == lat + 1) rv_after = res_valid;
                if (res_valid && lat < 0) begin
                    lat = k;
                    rd  = res_data;
                    rt  = res_tag;
                end
            end
            check($sformatf("tbl%0d_cnt_valid_on", i), 32'(cv1), 1);
            check($sformatf("tbl%0d_cnt_valid_off", i), 32'(cv2), 0);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 4);
            check($sformatf("tbl%0d_res_pulse", i), 32'(rv_after), 0);
            check($sformatf("tbl%0d_res_data", i), 32'(rd), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_res_tag", i), 32'(rt), 32'(i));
            @(posedge clk); #1;
        end

        // Fill to DEPTH with the counter stalled; the fifth word must wait
        for (int i = 0; i < 5; i++) t2[i] = $urandom;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = t2[i];
            @(posedge clk); #1;
        end
        in_data = t2[4];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 0);
            check("full_fill", 32'(fill), DEPTH);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        acc   = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) report_fail("full_fifth_accept", "never_ready", "accepted");
        drain("full_drain");

        // Simultaneous push and pop at fill=2
        stall    = 1'b1;
        t2[0]    = 32'hA5A5_0001;
        t2[1]    = 32'h5A5A_0002;
        t2[2]    = 32'hC3C3_0003;
        in_valid = 1'b1;
        in_data  = t2[0];
        @(posedge clk); #1;
        in_data = t2[1];
        @(posedge clk); #1;
        in_data = t2[2];
        stall   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pushpop_fill", 32'(fill), 2);
        check("pushpop_cnt_valid", 32'(cnt_valid), 1);
        check("pushpop_oldest", cnt_data, t2[0]);
        @(posedge clk); #1;
        drain("pushpop_drain");

        // Burst of 18 with tag wrap; counter returns the word index
        do_reset();
        mode     = 1;
        n_before = n_res;
        for (int i = 0; i < 18; i++) send({$urandom_range(0, 32'h03FF_FFFF), 6'(i)} );
        drain("burst_drain");
        check("burst_results", n_res - n_before, 18);
        mode = 0;

        // Randomized traffic with variable counter turnaround
        for (int c = 0; c < 300; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            hold_low = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        hold_low = 1'b0;
        drain("random_drain");

        // Reset while waiting for Ready to return, with two words queued
        hold_low = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_busy_before", 32'(busy), 1);
        check("midrst_fill_before", 32'(fill), 2);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("midrst_fill", 32'(fill), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_cnt_valid", 32'(cnt_valid), 0);
        hold_low = 1'b0;
        spur     = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) spur++;
        end
        check("midrst_no_result", 32'(spur), 0);
        @(posedge clk); #1;

        // Counter never acknowledges the start pulse
        no_resp = 1'b1;
`ifdef BCF_TIMEOUT_EN
        expect_timeout = 1'b1;
        send(32'h0000_0F0F);
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            if (res_valid) begin
                acc = 1'b1;
                check("wd_res_data", 32'(res_data), 32'h3F);
                check("wd_err", 32'(err), 1);
                check("wd_busy", 32'(busy), 0);
            end
        end
        if (!acc) report_fail("wd_result", "none", "timeout_result");
        @(posedge clk); #1;
        expect_timeout = 1'b0;
        no_resp        = 1'b0;
        do_reset();
        @(negedge clk);
        check("wd_err_cleared", 32'(err), 0);
        @(posedge clk); #1;
`else
        send(32'h0000_0F0F);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("stuck_busy", 32'(busy), 1);
        check("stuck_err", 32'(err), 0);
        check("stuck_res_valid", 32'(res_valid), 0);
        @(posedge clk); #1;
        no_resp = 1'b0;
        do_reset();
        @(negedge clk);
        check("stuck_busy_after_rst", 32'(busy), 0);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
